vec_mul_arb: RTL and testbench

VEC_MUL_ARB -- requirements
Module: vec_mul_arb

---
 rtl/vec_mul_pkg.sv | 18 +
 rtl/vec_mul_arb_if.sv | 46 ++++
 rtl/vec_mul_arb_tag_fifo.sv | 49 ++++
 rtl/vec_mul_arb.sv | 123 ++++++++++++
 tb/tb_vec_mul_arb.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/vec_mul_pkg.sv
// Shared types for the vector-multiplier arbiter: FSM state encoding and
// requester-ID width.
package vec_mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned REQ_ID_W = 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/vec_mul_arb_if.sv
// Handshake bundle between two requesters, the shared multiplier and the
// arbiter. Member names keep the original flat-port names.
interface vec_mul_arb_if #(
    parameter int unsigned BW_I       = 8,
    parameter int unsigned BW_O       = 16,
    parameter int unsigned VECTOR_LEN = 13
);
    logic [2*VECTOR_LEN*BW_I-1:0] req_data1_i;
    logic [2*VECTOR_LEN*BW_I-1:0] req_data2_i;
    logic [1:0]                   req_valid_i;
    logic [1:0]                   req_last_i;
    logic [1:0]                   req_ready_o;
    logic [VECTOR_LEN*BW_I-1:0]   mul_data1_o;
    logic [VECTOR_LEN*BW_I-1:0]   mul_data2_o;
    logic                         mul_valid_o;
    logic                         mul_last_o;
    logic                         mul_ready_i;
    logic [VECTOR_LEN*BW_O-1:0]   mul_res_i;
    logic                         mul_res_valid_i;
    logic                         mul_res_last_i;
    logic                         mul_res_ready_o;
    logic [VECTOR_LEN*BW_O-1:0]   res_data_o;
    logic [1:0]                   res_valid_o;
    logic [1:0]                   res_last_o;
    logic [1:0]                   res_ready_i;
    logic                         err_o;

    modport slave (
        input  req_data1_i, req_data2_i, req_valid_i, req_last_i,
               mul_ready_i, mul_res_i, mul_res_valid_i, mul_res_last_i,
               res_ready_i,
        output req_ready_o, mul_data1_o, mul_data2_o, mul_valid_o,
               mul_last_o, mul_res_ready_o, res_data_o, res_valid_o,
               res_last_o, err_o
    );

    modport master (
        output req_data1_i, req_data2_i, req_valid_i, req_last_i,
               mul_ready_i, mul_res_i, mul_res_valid_i, mul_res_last_i,
               res_ready_i,
        input  req_ready_o, mul_data1_o, mul_data2_o, mul_valid_o,
               mul_last_o, mul_res_ready_o, res_data_o, res_valid_o,
               res_last_o, err_o
    );

endinterface

// File: rtl/vec_mul_arb_tag_fifo.sv
// Small owner-tag FIFO recording which requester each in-flight packet
// belongs to. DEPTH must be a power of two.
module tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout_o  = mem[rd_ptr[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din_i;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vec_mul_arb.sv
// Two-requester packet arbiter for a shared vector multiplier; results are
// routed back to their owner in order via the tag FIFO.
module vec_mul_arb
    import vec_mul_pkg::*;
#(
    parameter int unsigned BW_I       = 8,
    parameter int unsigned BW_O       = 16,
    parameter int unsigned VECTOR_LEN = 13,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vec_mul_arb_if.slave  io
);
    localparam int unsigned VW = VECTOR_LEN * BW_I;
    localparam int unsigned RW = VECTOR_LEN * BW_O;

    state_t        state;
    req_id_t       owner;
    req_id_t       rr_ptr;
    req_id_t       grant_id;
    req_id_t       head;
    logic          busy;
    logic          grant;
    logic          fifo_full;
    logic          fifo_empty;
    logic          mul_valid;
    logic          mul_last;
    logic          pkt_done;
    logic          res_pop;
    logic          err_q;
    logic [1:0]    req_ready;
    logic [1:0]    res_valid;
    logic [1:0]    res_last;
    logic [RW-1:0] res_data;

    assign busy = (state == BUSY);

    always_comb begin
        grant_id = '0;
        case (io.req_valid_i)
            2'b11:   grant_id = rr_ptr;
            2'b10:   grant_id = 1'b1;
            default: grant_id = 1'b0;
        endcase
    end

    assign grant     = (state == IDLE) && (|io.req_valid_i) && !fifo_full;
    assign mul_valid = busy && io.req_valid_i[owner];
    assign mul_last  = busy && io.req_last_i[owner];
    assign pkt_done  = mul_valid && io.mul_ready_i && mul_last;
    assign res_pop   = !fifo_empty && io.mul_res_valid_i && io.mul_res_last_i
                       && io.res_ready_i[head];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state <= BUSY;
                    owner <= grant_id;
                end
                BUSY: if (pkt_done) begin
                    state  <= IDLE;
                    rr_ptr <= other_req(owner);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (fifo_empty && io.mul_res_valid_i) begin
            err_q <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (REQ_ID_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (res_pop),
        .din_i   (grant_id),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        req_ready = '0;
        res_valid = '0;
        res_last  = '0;
        if (busy) begin
            req_ready[owner] = io.mul_ready_i;
        end
        if (!fifo_empty) begin
            res_valid[head] = io.mul_res_valid_i;
            res_last[head]  = io.mul_res_last_i;
        end
    end

    assign res_data = io.mul_res_i;

    assign io.mul_data1_o     = owner ? io.req_data1_i[2*VW-1:VW] : io.req_data1_i[VW-1:0];
    assign io.mul_data2_o     = owner ? io.req_data2_i[2*VW-1:VW] : io.req_data2_i[VW-1:0];
    assign io.mul_valid_o     = mul_valid;
    assign io.mul_last_o      = mul_last;
    assign io.req_ready_o     = req_ready;
    assign io.res_valid_o     = res_valid;
    assign io.res_last_o      = res_last;
    assign io.res_data_o      = res_data;
    assign io.mul_res_ready_o = !fifo_empty && io.res_ready_i[head];
    assign io.err_o           = err_q;

endmodule

// File: tb/tb_vec_mul_arb.sv
// Directed self-checking bench for vec_mul_arb: grant/rr order, tag FIFO
// full/return routing, error flag and mid-packet reset.
module tb_vec_mul_arb;
    localparam int unsigned BW_I = 8;
    localparam int unsigned BW_O = 16;
    localparam int unsigned VL   = 13;
    localparam int unsigned VW   = VL * BW_I;
    localparam int unsigned RW   = VL * BW_O;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vec_mul_arb_if #(.BW_I(BW_I), .BW_O(BW_O), .VECTOR_LEN(VL)) io ();

    vec_mul_arb #(.BW_I(BW_I), .BW_O(BW_O), .VECTOR_LEN(VL), .TAG_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (io)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [VW-1:0] a, input logic [VW-1:0] b);
        io.req_data1_i[k*VW +: VW] = a;
        io.req_data2_i[k*VW +: VW] = b;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, 256'(io.req_ready_o), 256'(2'b00));
        chk({tag, "_mul_valid"}, 256'(io.mul_valid_o), 256'(1'b0));
        chk({tag, "_res_valid"}, 256'(io.res_valid_o), 256'(2'b00));
        chk({tag, "_mul_res_ready"}, 256'(io.mul_res_ready_o), 256'(1'b0));
        chk({tag, "_err"}, 256'(io.err_o), 256'(1'b0));
    endtask

    logic [VW-1:0] a0, a1, a2, b0, b1, b2;
    logic [RW-1:0] r0;

    initial begin
        a0 = {VL{8'h11}}; a1 = {VL{8'h22}}; a2 = {VL{8'h33}};
        b0 = {VL{8'hA5}}; b1 = {VL{8'h5A}}; b2 = {VL{8'hC3}};
        r0 = {VL{16'hBEEF}};
        rst = 1'b1;
        io.req_data1_i = '0; io.req_data2_i = '0;
        io.req_valid_i = '0; io.req_last_i = '0;
        io.mul_ready_i = 1'b0; io.mul_res_i = '0;
        io.mul_res_valid_i = 1'b0; io.mul_res_last_i = 1'b0;
        io.res_ready_i = 2'b11;
        #2;
        chk_quiet("reset");
        tick();
        rst = 1'b0;

        // Single requester, 3-beat packet
        set_ops(0, a0, b0);
        io.req_valid_i = 2'b01; io.mul_ready_i = 1'b1;
        #1;
        chk("a_idle_ready", 256'(io.req_ready_o), 256'(2'b00));
        chk("a_idle_valid", 256'(io.mul_valid_o), 256'(1'b0));
        tick();
        chk("a_grant_ready", 256'(io.req_ready_o), 256'(2'b01));
        chk("a_grant_valid", 256'(io.mul_valid_o), 256'(1'b1));
        chk("a_beat0_d1", 256'(io.mul_data1_o), 256'(a0));
        chk("a_beat0_d2", 256'(io.mul_data2_o), 256'(b0));
        chk("a_beat0_last", 256'(io.mul_last_o), 256'(1'b0));
        io.mul_res_valid_i = 1'b1; io.res_ready_i = 2'b00;
        #1;
        chk("a_tag0_route", 256'(io.res_valid_o), 256'(2'b01));
        io.mul_res_valid_i = 1'b0; io.res_ready_i = 2'b11;
        tick();
        set_ops(0, a1, b1);
        #1;
        chk("a_beat1_d1", 256'(io.mul_data1_o), 256'(a1));
        chk("a_beat1_valid", 256'(io.mul_valid_o), 256'(1'b1));
        tick();
        set_ops(0, a2, b2); io.req_last_i = 2'b01;
        #1;
        chk("a_beat2_d2", 256'(io.mul_data2_o), 256'(b2));
        chk("a_beat2_last", 256'(io.mul_last_o), 256'(1'b1));
        tick();
        io.req_valid_i = 2'b00; io.req_last_i = 2'b00;
        #1;
        chk("a_back_idle_valid", 256'(io.mul_valid_o), 256'(1'b0));
        chk("a_back_idle_ready", 256'(io.req_ready_o), 256'(2'b00));

        rst = 1'b1; #1; rst = 1'b0;

        // Both requesters valid, single-beat packets; results withheld
        set_ops(0, a0, b0); set_ops(1, a1, b1);
        io.req_valid_i = 2'b11; io.req_last_i = 2'b11;
        tick();
        chk("b_first_owner", 256'(io.req_ready_o), 256'(2'b01));
        chk("b_first_d1", 256'(io.mul_data1_o), 256'(a0));
        tick();
        chk("b_idle_between", 256'(io.req_ready_o), 256'(2'b00));
        tick();
        chk("b_second_owner", 256'(io.req_ready_o), 256'(2'b10));
        chk("b_second_d1", 256'(io.mul_data1_o), 256'(a1));
        tick();
        tick();
        chk("b_tie_again_owner", 256'(io.req_ready_o), 256'(2'b01));
        tick();
        tick();
        chk("c_fourth_owner", 256'(io.req_ready_o), 256'(2'b10));
        tick();
        chk("c_full_no_grant_ready", 256'(io.req_ready_o), 256'(2'b00));
        chk("c_full_no_grant_valid", 256'(io.mul_valid_o), 256'(1'b0));
        tick();
        chk("c_full_still_blocked", 256'(io.mul_valid_o), 256'(1'b0));

        // Return results in order; requester 0 not ready at first
        io.mul_res_i = r0; io.mul_res_valid_i = 1'b1; io.mul_res_last_i = 1'b1;
        io.res_ready_i = 2'b10;
        #1;
        chk("d_head0_valid", 256'(io.res_valid_o), 256'(2'b01));
        chk("d_head0_last", 256'(io.res_last_o), 256'(2'b01));
        chk("d_stall_ready", 256'(io.mul_res_ready_o), 256'(1'b0));
        chk("d_res_data", 256'(io.res_data_o), 256'(r0));
        tick();
        chk("d_stall_holds", 256'(io.res_valid_o), 256'(2'b01));
        chk("d_stall_no_grant", 256'(io.req_ready_o), 256'(2'b00));
        io.res_ready_i = 2'b11;
        #1;
        chk("d_accept_ready", 256'(io.mul_res_ready_o), 256'(1'b1));
        tick();
        chk("d_head1_valid", 256'(io.res_valid_o), 256'(2'b10));
        chk("d_head1_last", 256'(io.res_last_o), 256'(2'b10));
        chk("d_idle_after_pop", 256'(io.req_ready_o), 256'(2'b00));
        tick();
        chk("d_fifth_granted", 256'(io.req_ready_o), 256'(2'b01));
        chk("d_push_pop_head", 256'(io.res_valid_o), 256'(2'b01));
        io.mul_res_valid_i = 1'b0; io.mul_res_last_i = 1'b0;
        io.req_valid_i = 2'b00; io.req_last_i = 2'b00;

        rst = 1'b1; #1; rst = 1'b0;

        // Result with no outstanding owner
        io.mul_res_valid_i = 1'b1;
        #1;
        chk("e_empty_res_valid", 256'(io.res_valid_o), 256'(2'b00));
        chk("e_empty_res_ready", 256'(io.mul_res_ready_o), 256'(1'b0));
        tick();
        chk("e_err_set", 256'(io.err_o), 256'(1'b1));
        io.mul_res_valid_i = 1'b0;
        tick();
        tick();
        chk("e_err_sticky", 256'(io.err_o), 256'(1'b1));
        rst = 1'b1; #1;
        chk("e_err_cleared", 256'(io.err_o), 256'(1'b0));
        rst = 1'b0;

        // Reset during beat 2 of a 4-beat packet
        set_ops(0, a0, b0);
        io.req_valid_i = 2'b01; io.req_last_i = 2'b00;
        tick();
        tick();
        tick();
        chk("f_beat2_valid", 256'(io.mul_valid_o), 256'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("f_midpkt_reset");
        rst = 1'b0;
        #1;
        chk("f_after_idle_valid", 256'(io.mul_valid_o), 256'(1'b0));
        chk("f_after_fifo_empty", 256'(io.mul_res_ready_o), 256'(1'b0));
        io.req_valid_i = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
